// File: rtl/resp_checker16.sv
// resp_checker16: response checker for the 16-bit gate benches.
// Each accepted sample is a DUT result and its expected value. The block
// counts vectors and mismatches, latches the index of the first failing
// vector, and gives a registered pass/fail verdict once the last vector
// has been accepted.
// Optional MISR signature over all DUT responses: define RESP_CHECKER_MISR_EN.
// When the macro is undefined, no MISR is built and signature_o is 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for first sample of a run; counters hold last clear
// RUN   | at least one non-final sample accepted
// DONE  | final sample accepted; verdict valid, samples ignored
module resp_checker16 #(
   parameter int              WIDTH = 16,
   parameter int              CNT_W = 8,
   parameter logic [WIDTH-1:0] POLY = 16'h1021
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   input  logic             last_i,
   input  logic [WIDTH-1:0] dut_i,
   input  logic [WIDTH-1:0] exp_i,
   input  logic             clr_i,
   output logic             ready_o,
   output logic             mismatch_o,
   output logic [CNT_W-1:0] vec_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o,
   output logic [CNT_W-1:0] first_err_o,
   output logic [WIDTH-1:0] signature_o,
   output logic             done_o,
   output logic             pass_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] first_err_q, first_err_d;
   logic             mismatch_q, mismatch_d;
   logic             pass_q, pass_d;
   logic             accept;

`ifdef RESP_CHECKER_MISR_EN
   localparam logic [WIDTH-1:0] SEED = {WIDTH{1'b1}};
   logic [WIDTH-1:0] sig_q, sig_d;
`endif

   assign accept = valid_i && (state_q != S_DONE);

   // Next-state, counter and capture logic; clear beats any sample in the same cycle.
   always_comb begin
      state_d     = state_q;
      vec_cnt_d   = vec_cnt_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      mismatch_d  = 1'b0;
`ifdef RESP_CHECKER_MISR_EN
      sig_d       = sig_q;
`endif
      if (clr_i) begin
         state_d     = S_IDLE;
         vec_cnt_d   = CNT_ZERO;
         err_cnt_d   = CNT_ZERO;
         first_err_d = CNT_ZERO;
`ifdef RESP_CHECKER_MISR_EN
         sig_d       = SEED;
`endif
      end else if (accept) begin
         if (vec_cnt_q != CNT_MAX) begin
            vec_cnt_d = vec_cnt_q + CNT_ONE;
         end
         if (dut_i != exp_i) begin
            mismatch_d = 1'b1;
            if (err_cnt_q == CNT_ZERO) begin
               first_err_d = vec_cnt_q;
            end
            if (err_cnt_q != CNT_MAX) begin
               err_cnt_d = err_cnt_q + CNT_ONE;
            end
         end
`ifdef RESP_CHECKER_MISR_EN
         sig_d = ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})) ^ dut_i;
`endif
         state_d = last_i ? S_DONE : S_RUN;
      end
      pass_d = (state_d == S_DONE) && (err_cnt_d == CNT_ZERO);
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         vec_cnt_q   <= CNT_ZERO;
         err_cnt_q   <= CNT_ZERO;
         first_err_q <= CNT_ZERO;
         mismatch_q  <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         vec_cnt_q   <= vec_cnt_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         mismatch_q  <= mismatch_d;
         pass_q      <= pass_d;
      end
   end

`ifdef RESP_CHECKER_MISR_EN
   // Signature register, reseeded on reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign signature_o = sig_q;
`else
   // No MISR: constant zero; the AND keeps POLY referenced.
   assign signature_o = POLY & {WIDTH{1'b0}};
`endif

   assign ready_o     = (state_q != S_DONE);
   assign done_o      = (state_q == S_DONE);
   assign pass_o      = pass_q;
   assign mismatch_o  = mismatch_q;
   assign vec_cnt_o   = vec_cnt_q;
   assign err_cnt_o   = err_cnt_q;
   assign first_err_o = first_err_q;

endmodule

// File: tb/tb_resp_checker16.sv
// Bench for resp_checker16: a wide-counter instance (CNT_W=8) and a narrow
// one (CNT_W=2) share all inputs; both are compared every cycle against a
// behavioural model, with directed scenarios followed by random traffic.
module tb_resp_checker16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        last = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] dut = '0;
   logic [15:0] expv = '0;

   logic        ready0, mis0, done0, pass0;
   logic [7:0]  vec0, err0, first0;
   logic [15:0] sig0;
   logic        ready1, mis1, done1, pass1;
   logic [1:0]  vec1, err1, first1;
   logic [15:0] sig1;

   int n_assert = 0;
   int n_fail = 0;

   // Model state: run finished flag, signature, per-instance counters.
   bit          m_done;
   bit          m_mis;
   logic [15:0] m_sig;
   int          m_vec[2];
   int          m_err[2];
   int          m_first[2];
   int          m_max[2] = '{255, 3};

   always #5 clk = ~clk;

   resp_checker16 #(.WIDTH(16), .CNT_W(8)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .last_i(last),
      .dut_i(dut), .exp_i(expv), .clr_i(clr),
      .ready_o(ready0), .mismatch_o(mis0), .vec_cnt_o(vec0), .err_cnt_o(err0),
      .first_err_o(first0), .signature_o(sig0), .done_o(done0), .pass_o(pass0)
   );

   resp_checker16 #(.WIDTH(16), .CNT_W(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .last_i(last),
      .dut_i(dut), .exp_i(expv), .clr_i(clr),
      .ready_o(ready1), .mismatch_o(mis1), .vec_cnt_o(vec1), .err_cnt_o(err1),
      .first_err_o(first1), .signature_o(sig1), .done_o(done1), .pass_o(pass1)
   );

`ifdef RESP_CHECKER_MISR_EN
   localparam logic [15:0] SIG_SEED = 16'hFFFF;
`else
   localparam logic [15:0] SIG_SEED = 16'h0000;
`endif

   function automatic logic [15:0] misr_next(input logic [15:0] s, input logic [15:0] d);
`ifdef RESP_CHECKER_MISR_EN
      return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ d;
`else
      return 16'h0000;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_assert++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic model_clear();
      m_done = 1'b0;
      m_mis  = 1'b0;
      m_sig  = SIG_SEED;
      for (int i = 0; i < 2; i++) begin
         m_vec[i] = 0; m_err[i] = 0; m_first[i] = 0;
      end
   endtask

   task automatic model_step();
      if (rst || clr) begin
         model_clear();
      end else if (valid && !m_done) begin
         m_mis = (dut != expv);
         for (int i = 0; i < 2; i++) begin
            if (m_mis) begin
               if (m_err[i] == 0) m_first[i] = m_vec[i];
               if (m_err[i] < m_max[i]) m_err[i]++;
            end
            if (m_vec[i] < m_max[i]) m_vec[i]++;
         end
         m_sig = misr_next(m_sig, dut);
         if (last) m_done = 1'b1;
      end else begin
         m_mis = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("ready0", ready0, !m_done);
      chk("done0", done0, m_done);
      chk("pass0", pass0, m_done && m_err[0] == 0);
      chk("mis0", mis0, m_mis);
      chk("vec0", vec0, m_vec[0]);
      chk("err0", err0, m_err[0]);
      chk("first0", first0, m_first[0]);
      chk("sig0", sig0, m_sig);
      chk("ready1", ready1, !m_done);
      chk("done1", done1, m_done);
      chk("pass1", pass1, m_done && m_err[1] == 0);
      chk("mis1", mis1, m_mis);
      chk("vec1", vec1, m_vec[1]);
      chk("err1", err1, m_err[1]);
      chk("first1", first1, m_first[1]);
      chk("sig1", sig1, m_sig);
   endtask

   // One clock: apply inputs, advance model at the edge, check 1 time unit later.
   task automatic cyc(input bit v, input bit l, input logic [15:0] d,
                      input logic [15:0] e, input bit c, input bit r);
      valid = v; last = l; dut = d; expv = e; clr = c; rst = r;
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin
      int n_mis;
      logic [15:0] rd;
      model_clear();

      // Reset
      cyc(0, 0, 16'h0, 16'h0, 0, 1);
      cyc(0, 0, 16'h0, 16'h0, 0, 1);
      chk("rst_ready", ready0, 1);
      chk("rst_vec", vec0, 0);
      chk("rst_sig", sig0, SIG_SEED);
      cyc(0, 0, 16'h0, 16'h0, 0, 0);

      // Clean run
      n_mis = 0;
      cyc(1, 0, 16'h0000, 16'h0000, 0, 0); n_mis += mis0;
      cyc(1, 0, 16'h0000, 16'h0000, 0, 0); n_mis += mis0;
      cyc(1, 0, 16'h0000, 16'h0000, 0, 0); n_mis += mis0;
      cyc(1, 0, 16'hFFFF, 16'hFFFF, 0, 0); n_mis += mis0;
      cyc(1, 1, 16'h2AA0, 16'h2AA0, 0, 0); n_mis += mis0;
      chk("clean_vec", vec0, 5);
      chk("clean_err", err0, 0);
      chk("clean_done", done0, 1);
      chk("clean_pass", pass0, 1);
      chk("clean_ready", ready0, 0);
      chk("clean_mis", n_mis, 0);

      // First-error capture
      cyc(0, 0, 16'h0, 16'h0, 1, 0);
      n_mis = 0;
      cyc(1, 0, 16'h1234, 16'h1234, 0, 0); n_mis += mis0;
      cyc(1, 0, 16'h5555, 16'h5555, 0, 0); n_mis += mis0;
      cyc(1, 0, 16'h2AA1, 16'h2AA0, 0, 0); n_mis += mis0;
      cyc(1, 0, 16'h00F0, 16'h00F0, 0, 0); n_mis += mis0;
      cyc(1, 1, 16'hFFFF, 16'h0000, 0, 0); n_mis += mis0;
      cyc(0, 0, 16'h0, 16'h0, 0, 0);       n_mis += mis0;
      chk("fe_pulses", n_mis, 2);
      chk("fe_err", err0, 2);
      chk("fe_first", first0, 2);
      chk("fe_pass", pass0, 0);
      chk("fe_done", done0, 1);

      // MISR single sample, then samples in DONE
      cyc(0, 0, 16'h0, 16'h0, 1, 0);
      cyc(1, 1, 16'h0000, 16'h0000, 0, 0);
`ifdef RESP_CHECKER_MISR_EN
      chk("misr_sig", sig0, 16'hEFDF);
`else
      chk("misr_sig", sig0, 16'h0000);
`endif
      cyc(1, 0, 16'hABCD, 16'h0000, 0, 0);
      cyc(1, 1, 16'h1357, 16'h1357, 0, 0);
      chk("done_vec", vec0, 1);
`ifdef RESP_CHECKER_MISR_EN
      chk("done_sig", sig0, 16'hEFDF);
`endif

      // Clear with simultaneous valid in DONE
      cyc(1, 0, 16'hDEAD, 16'hBEEF, 1, 0);
      chk("clr_ready", ready0, 1);
      chk("clr_vec", vec0, 0);
      chk("clr_err", err0, 0);
      chk("clr_sig", sig0, SIG_SEED);

      // Mid-run reset with valid
      cyc(1, 0, 16'h0001, 16'h0001, 0, 0);
      cyc(1, 0, 16'h0002, 16'h0003, 0, 0);
      cyc(1, 0, 16'h0004, 16'h0004, 0, 0);
      chk("pre_rst_err", err0, 1);
      cyc(1, 1, 16'h0F0F, 16'hF0F0, 0, 1);
      chk("mr_err", err0, 0);
      chk("mr_vec", vec0, 0);
      chk("mr_mis", mis0, 0);
      chk("mr_done", done0, 0);
      chk("mr_sig", sig0, SIG_SEED);

      // Saturation on narrow instance
      for (int i = 0; i < 6; i++) cyc(1, 0, 16'h00FF, 16'h0F00, 0, 0);
      chk("sat_vec", vec1, 3);
      chk("sat_err", err1, 3);
      chk("sat_first", first1, 0);
      chk("sat_vec_wide", vec0, 6);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rd = 16'($urandom);
         cyc($urandom_range(0, 9) < 7,
             $urandom_range(0, 9) == 0,
             rd,
             ($urandom_range(0, 9) < 3) ? (rd ^ (16'h1 << $urandom_range(0, 15))) : rd,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 49) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
